// File: rtl/lhca_trng.sv
// Hybrid rule-90/150 cellular-automaton TRNG with synchronised ring-oscillator injection,
// warm-up, decimation, repetition-count health test and valid/ready output.
module lhca_trng #(
   parameter int unsigned      WIDTH       = 32,
   parameter int unsigned      NUM_SRC     = 32,
   parameter logic [WIDTH-1:0] RULE        = '0,
   parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
   parameter int unsigned      SYNC_STAGES = 2,
   parameter int unsigned      WARMUP      = 64,
   parameter int unsigned      DECIM       = 8,
   parameter int unsigned      REP_LIMIT   = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_SRC-1:0] source,
   output logic               rand_valid,
   input  logic               rand_ready,
   output logic [WIDTH-1:0]   rand_data,
   output logic               health_fail
);

   typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_FAIL} state_t;

   state_t             state, state_nxt;
   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] sync_out;
   logic [WIDTH-1:0]   src_word;
   logic [WIDTH-1:0]   ca, ca_nxt;
   logic [WIDTH+1:0]   ca_pad;
   logic               p, prev_p;
   logic [31:0]        rep_cnt, rep_nxt;
   logic [31:0]        warm_cnt, dec_cnt;
   logic               active, trip, warm_done, dec_done, load;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= source;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // Sources beyond WIDTH wrap around and are XOR-folded onto the same cell.
   always_comb begin
      src_word = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++)
         src_word[k % WIDTH] = src_word[k % WIDTH] ^ sync_out[k];
   end

   // Zero-padded copy gives the null boundary cells on both ends.
   assign ca_pad = {1'b0, ca, 1'b0};
   assign ca_nxt = ca_pad[WIDTH+1:2] ^ ca_pad[WIDTH-1:0] ^ (RULE & ca) ^ src_word;
   assign p      = ^src_word;
   assign active = (state == S_WARMUP) || (state == S_RUN);

   // rep_cnt of 0 marks "no sample yet since entering warm-up".
   always_comb begin
      if (rep_cnt == '0 || p != prev_p) rep_nxt = 32'd1;
      else if (rep_cnt >= 32'(REP_LIMIT)) rep_nxt = rep_cnt;
      else rep_nxt = rep_cnt + 32'd1;
   end

   assign trip      = active && (rep_nxt >= 32'(REP_LIMIT));
   assign warm_done = (warm_cnt + 32'd1) == 32'(WARMUP);
   assign dec_done  = (dec_cnt + 32'd1) == 32'(DECIM);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (en) state_nxt = (WARMUP == 0) ? S_RUN : S_WARMUP;
         S_WARMUP: if (trip) state_nxt = S_FAIL;
                   else if (!en) state_nxt = S_IDLE;
                   else if (warm_done) state_nxt = S_RUN;
         S_RUN:    if (trip) state_nxt = S_FAIL;
                   else if (!en) state_nxt = S_IDLE;
         S_FAIL:   state_nxt = S_FAIL;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      health_fail = (state == S_FAIL);
   end

   assign load = (state == S_RUN) && (state_nxt == S_RUN) && dec_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         ca         <= SEED;
         prev_p     <= 1'b0;
         rep_cnt    <= '0;
         warm_cnt   <= '0;
         dec_cnt    <= '0;
         rand_valid <= 1'b0;
         rand_data  <= '0;
      end else begin
         if (active) begin
            ca      <= ca_nxt;
            prev_p  <= p;
            rep_cnt <= rep_nxt;
         end
         if (state == S_IDLE) rep_cnt <= '0;
         warm_cnt <= (state == S_WARMUP) ? warm_cnt + 32'd1 : '0;
         dec_cnt  <= (state == S_RUN && !dec_done) ? dec_cnt + 32'd1 : '0;
         // A completed word is dropped if the previous one is still unaccepted.
         if (state_nxt != S_RUN) begin
            rand_valid <= 1'b0;
         end else if (load && (!rand_valid || rand_ready)) begin
            rand_valid <= 1'b1;
            rand_data  <= ca_nxt;
         end else if (rand_ready) begin
            rand_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_lhca_trng.sv
// Directed bench for lhca_trng: reset, deterministic CA, health failure, backpressure,
// enable drop and a long run with jittered ring-oscillator sources.
`timescale 1ns/1ps
module tb_lhca_trng;

   logic        clk, rst;
   logic        en_a, rdy_a, val_a, hf_a;
   logic [7:0]  src_a, dat_a;
   logic        en_b, rdy_b, val_b, hf_b;
   logic [11:0] src_b;
   logic [7:0]  dat_b;
   logic        en_c, rdy_c, val_c, hf_c;
   logic [31:0] src_c, dat_c;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned hs_b  = 0;
   logic        tog   = 1'b0;

   lhca_trng #(.WIDTH(8), .NUM_SRC(8), .RULE(8'h00), .SEED(8'h01), .SYNC_STAGES(2),
               .WARMUP(2), .DECIM(1), .REP_LIMIT(64)) dut_a (
      .clk(clk), .rst(rst), .en(en_a), .source(src_a), .rand_valid(val_a),
      .rand_ready(rdy_a), .rand_data(dat_a), .health_fail(hf_a));

   lhca_trng #(.WIDTH(8), .NUM_SRC(12), .RULE(8'h5A), .SEED(8'h01), .SYNC_STAGES(3),
               .WARMUP(3), .DECIM(4), .REP_LIMIT(16)) dut_b (
      .clk(clk), .rst(rst), .en(en_b), .source(src_b), .rand_valid(val_b),
      .rand_ready(rdy_b), .rand_data(dat_b), .health_fail(hf_b));

   lhca_trng #(.WIDTH(32), .NUM_SRC(32), .RULE(32'h6ED3_8B14), .SEED(32'h1), .SYNC_STAGES(2),
               .WARMUP(64), .DECIM(8), .REP_LIMIT(32)) dut_c (
      .clk(clk), .rst(rst), .en(en_c), .source(src_c), .rand_valid(val_c),
      .rand_ready(rdy_c), .rand_data(dat_c), .health_fail(hf_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running oscillators with per-source base period and random jitter.
   for (genvar g = 0; g < 32; g++) begin : g_ro
      logic r = 1'b0;
      always begin
         #(2 + (g % 6) + $urandom_range(2, 0));
         r = ~r;
      end
      assign src_c[g] = r;
   end

   function automatic logic [7:0] ca8(input logic [7:0] s, input logic [7:0] rule);
      return (s << 1) ^ (s >> 1) ^ (rule & s);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      if (val_b && rdy_b) hs_b++;
      @(posedge clk);
      #1;
      if (tog) src_b[0] = ~src_b[0];
   endtask

   logic [7:0]  m, m7, m16, w0;
   logic [31:0] prev_w;
   int unsigned words, dups, pres, cyc;
   logic        hs, pv;

   initial begin
      rst = 1'b1;
      en_a = 1'b0; rdy_a = 1'b0; en_b = 1'b0; rdy_b = 1'b0; en_c = 1'b0; rdy_c = 1'b0;
      src_a = 8'($urandom); src_b = 12'($urandom);
      tick();
      src_a = '0; src_b = '0;
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_valid_a", val_a, 0);
      chk("rst_data_a", dat_a, 0);
      chk("rst_fail_a", hf_a, 0);
      chk("rst_ca_a", dut_a.ca, 8'h01);
      chk("rst_valid_b", val_b, 0);
      chk("rst_ca_b", dut_b.ca, 8'h01);
      chk("rst_valid_c", val_c, 0);
      chk("rst_fail_c", hf_c, 0);
      chk("rst_ca_c", dut_c.ca, 32'h1);

      // Deterministic CA: rule 90, seed 01, zero sources
      en_a = 1'b1; rdy_a = 1'b1;
      tick();
      chk("det_e0_valid", val_a, 0);
      chk("det_e0_ca", dut_a.ca, 8'h01);
      tick();
      chk("det_e1_ca", dut_a.ca, 8'h02);
      tick();
      chk("det_e2_valid", val_a, 0);
      chk("det_e2_ca", dut_a.ca, 8'h05);
      tick();
      chk("det_e3_valid", val_a, 1);
      chk("det_e3_data", dat_a, 8'h08);
      m = 8'h08;
      for (int i = 0; i < 12; i++) begin
         tick();
         m = ca8(m, 8'h00);
         chk("det_stream_valid", val_a, 1);
         chk("det_stream_data", dat_a, m);
      end
      en_a = 1'b0;
      tick();
      chk("det_en_drop_valid", val_a, 0);

      // Health failure: constant sources, REP_LIMIT 16
      m = 8'h01;
      for (int i = 1; i <= 16; i++) begin
         m = ca8(m, 8'h5A);
         if (i == 7) m7 = m;
      end
      m16 = m;
      en_b = 1'b1; rdy_b = 1'b0;
      tick();
      for (int e = 1; e <= 15; e++) begin
         tick();
         if (e == 6) chk("hf_e6_valid", val_b, 0);
         if (e == 7) begin
            chk("hf_e7_valid", val_b, 1);
            chk("hf_e7_data", dat_b, m7);
         end
      end
      chk("hf_e15_fail", hf_b, 0);
      chk("hf_e15_data_held", dat_b, m7);
      tick();
      chk("hf_e16_fail", hf_b, 1);
      chk("hf_e16_valid", val_b, 0);
      chk("hf_e16_ca", dut_b.ca, m16);
      for (int i = 0; i < 6; i++) begin
         en_b = ~en_b;
         tick();
         chk("hf_sticky", hf_b, 1);
         chk("hf_valid_low", val_b, 0);
         chk("hf_ca_frozen", dut_b.ca, m16);
      end
      rst = 1'b1; en_b = 1'b0;
      tick(); tick();
      rst = 1'b0;
      chk("hf_rst_fail", hf_b, 0);
      chk("hf_rst_valid", val_b, 0);
      chk("hf_rst_data", dat_b, 0);
      chk("hf_rst_ca", dut_b.ca, 8'h01);

      // Backpressure: alternating source parity keeps the health test quiet
      tog = 1'b1;
      tick(); tick(); tick();
      en_b = 1'b1; rdy_b = 1'b0; hs_b = 0;
      tick();
      for (int e = 1; e <= 6; e++) tick();
      chk("bp_e6_valid", val_b, 0);
      tick();
      chk("bp_e7_valid", val_b, 1);
      w0 = dat_b;
      for (int e = 8; e <= 59; e++) begin
         tick();
         chk("bp_hold_valid", val_b, 1);
         chk("bp_hold_data", dat_b, w0);
      end
      // Pulse lands one edge after a decimation boundary; next word three edges later.
      rdy_b = 1'b1;
      tick();
      rdy_b = 1'b0;
      chk("bp_pulse_valid", val_b, 0);
      chk("bp_transfers", hs_b, 1);
      tick();
      chk("bp_gap1_valid", val_b, 0);
      tick();
      chk("bp_gap2_valid", val_b, 0);
      tick();
      chk("bp_next_valid", val_b, 1);
      chk("bp_no_fail", hf_b, 0);

      // Enable drop with a held word, then full warm-up on re-enable
      en_b = 1'b0;
      tick();
      chk("ed_valid_low", val_b, 0);
      tick(); tick();
      en_b = 1'b1;
      tick();
      for (int e = 1; e <= 6; e++) tick();
      chk("ed_e6_valid", val_b, 0);
      tick();
      chk("ed_e7_valid", val_b, 1);
      chk("ed_no_fail", hf_b, 0);
      en_b = 1'b0; tog = 1'b0;
      tick();

      // Jittered sources, 1000 accepted words
      en_c = 1'b1;
      words = 0; dups = 0; pres = 0; cyc = 0; pv = 1'b0; prev_w = '0;
      while (words < 1000 && cyc < 20000) begin
         rdy_c = ($urandom_range(3, 0) != 0);
         hs = val_c && rdy_c;
         if (hs) begin
            if (words > 0 && dat_c === prev_w) dups++;
            prev_w = dat_c;
            words++;
         end
         tick();
         cyc++;
         if (val_c && (hs || !pv)) pres++;
         pv = val_c;
      end
      rdy_c = 1'b0;
      chk("rnd_words_in_budget", words, 1000);
      chk("rnd_no_fail", hf_c, 0);
      chk("rnd_no_repeat", dups, 0);
      chk("rnd_word_count", pres, words + 32'(val_c));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
